para_load_ctrl: RTL and testbench

- Sequencer in front of the per-layer parameter loader: accepts a valid/ready parameter stream from the off-chip/DMA side and drives the loader's valid, mode, data and reset inputs.
- Clears the loader before each load so reloads work without a global reset.
- Counts the full parameter image: FM_DEPTH RSign words, then CHANNEL_NUM words each for bn_a, bn_b, beta, gamma and zeta.
- Reports when parameters are valid, so the layer may switch to compute mode.

---
 rtl/para_pkg.sv | 26 ++
 rtl/para_load_ctrl_if.sv | 22 ++
 rtl/para_seg_counter.sv | 55 +++++
 rtl/para_load_ctrl.sv | 125 ++++++++++++
 tb/tb_para_load_ctrl.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/para_pkg.sv
// Shared types and sizing for the parameter-load sequencer.
package para_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_LOAD  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_READY = 3'd4
  } state_e;

  localparam int FM_DEPTH_DEF    = 64;
  localparam int CHANNEL_NUM_DEF = 128;
  localparam int PARA_NUM_DEF    = 6;
  localparam int PARA_WIDTH_DEF  = 16;
  localparam int CLR_CYCLES_DEF  = 2;

  // Words in one full image: RSign segment plus (PARA_NUM-1) channel segments.
  function automatic int total_words(input int fm, input int ch, input int pn);
    return fm + (pn - 1) * ch;
  endfunction

  localparam int TOTAL_DEF = total_words(FM_DEPTH_DEF, CHANNEL_NUM_DEF, PARA_NUM_DEF);
  localparam int CW        = $clog2(TOTAL_DEF + 1);

endpackage

// File: rtl/para_load_ctrl_if.sv
// Source stream in, loader drive out. slave = sequencer, master = stream/loader side.
interface para_load_ctrl_if #(
  parameter int PARA_WIDTH = 16
) ();
  logic                         src_valid;
  logic signed [PARA_WIDTH-1:0] src_data;
  logic                         src_ready;
  logic                         ld_rstn;
  logic                         ld_valid;
  logic                         ld_mode;
  logic signed [PARA_WIDTH-1:0] ld_para;

  modport slave (
    input  src_valid, src_data,
    output src_ready, ld_rstn, ld_valid, ld_mode, ld_para
  );

  modport master (
    output src_valid, src_data,
    input  src_ready, ld_rstn, ld_valid, ld_mode, ld_para
  );
endinterface

// File: rtl/para_seg_counter.sv
// Word / segment counter for one parameter image: segment 0 is FM_DEPTH words,
// later segments are CHANNEL_NUM words; seg index saturates at the last segment.
module para_seg_counter
  import para_pkg::*;
#(
  parameter int FM_DEPTH    = FM_DEPTH_DEF,
  parameter int CHANNEL_NUM = CHANNEL_NUM_DEF,
  parameter int PARA_NUM    = PARA_NUM_DEF,
  parameter int CNT_W       = 10
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] word_cnt_o,
  output logic [2:0]       seg_idx_o,
  output logic             last_word_o
);
  localparam int TOTAL = total_words(FM_DEPTH, CHANNEL_NUM, PARA_NUM);
  localparam logic [CNT_W-1:0] SEG0_LAST = CNT_W'(FM_DEPTH - 1);
  localparam logic [CNT_W-1:0] SEGN_LAST = CNT_W'(CHANNEL_NUM - 1);
  localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(TOTAL - 1);
  localparam logic [2:0]       SEG_MAX   = 3'(PARA_NUM - 1);

  logic [CNT_W-1:0] word_cnt_q, seg_word_q;
  logic [2:0]       seg_idx_q;
  logic             seg_end;

  assign seg_end     = seg_word_q == ((seg_idx_q == 3'd0) ? SEG0_LAST : SEGN_LAST);
  assign last_word_o = word_cnt_q == WORD_LAST;
  assign word_cnt_o  = word_cnt_q;
  assign seg_idx_o   = seg_idx_q;

  // Count accepted words; roll the in-segment offset and bump segment at boundaries.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      word_cnt_q <= '0;
      seg_word_q <= '0;
      seg_idx_q  <= '0;
    end else if (clr_i) begin
      word_cnt_q <= '0;
      seg_word_q <= '0;
      seg_idx_q  <= '0;
    end else if (inc_i) begin
      word_cnt_q <= word_cnt_q + CNT_W'(1);
      if (seg_end) begin
        seg_word_q <= '0;
        if (seg_idx_q != SEG_MAX) seg_idx_q <= seg_idx_q + 3'd1;
      end else begin
        seg_word_q <= seg_word_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/para_load_ctrl.sv
// Sequencer ahead of the per-layer parameter loader: clear, stream the image,
// drain the last word, then flag parameters valid (run mode).
module para_load_ctrl
  import para_pkg::*;
#(
  parameter int FM_DEPTH    = FM_DEPTH_DEF,
  parameter int CHANNEL_NUM = CHANNEL_NUM_DEF,
  parameter int PARA_NUM    = PARA_NUM_DEF,
  parameter int PARA_WIDTH  = PARA_WIDTH_DEF,
  parameter int CLR_CYCLES  = CLR_CYCLES_DEF,
  parameter int CNT_W       = $clog2(total_words(FM_DEPTH, CHANNEL_NUM, PARA_NUM) + 1)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic               abort,
  para_load_ctrl_if.slave    bus,
  output logic               busy,
  output logic               para_ok,
  output logic               load_done,
  output logic [2:0]         seg_idx,
  output logic [CNT_W-1:0]   word_cnt
);
  localparam int CLRW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam logic [CLRW-1:0] CLR_LAST = CLRW'(CLR_CYCLES - 1);

  state_e                  state_q;
  logic [CLRW-1:0]         clr_cnt_q;
  logic                    ld_rstn_q, ld_valid_q, ld_mode_q;
  logic [PARA_WIDTH-1:0]   ld_para_q;
  logic                    busy_q, para_ok_q, load_done_q;
  logic                    hs, start_acc, abort_acc, last_word;

  // Ready is purely a function of state so the source never sees back-pressure in LOAD.
  assign bus.src_ready = (state_q == ST_LOAD);
  assign hs            = bus.src_valid && (state_q == ST_LOAD);
  assign abort_acc     = abort && ((state_q == ST_CLR) || (state_q == ST_LOAD));
  // abort beats start; start only counts from IDLE or READY.
  assign start_acc     = start && !abort && ((state_q == ST_IDLE) || (state_q == ST_READY));

  para_seg_counter #(
    .FM_DEPTH   (FM_DEPTH),
    .CHANNEL_NUM(CHANNEL_NUM),
    .PARA_NUM   (PARA_NUM),
    .CNT_W      (CNT_W)
  ) u_cnt (
    .clk        (clk),
    .rstn       (rstn),
    .clr_i      (start_acc),
    .inc_i      (hs && !abort),
    .word_cnt_o (word_cnt),
    .seg_idx_o  (seg_idx),
    .last_word_o(last_word)
  );

  // Sequencer FSM with registered loader drive and status outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      clr_cnt_q   <= '0;
      ld_rstn_q   <= 1'b1;
      ld_valid_q  <= 1'b0;
      ld_mode_q   <= 1'b1;
      ld_para_q   <= '0;
      busy_q      <= 1'b0;
      para_ok_q   <= 1'b0;
      load_done_q <= 1'b0;
    end else begin
      load_done_q <= 1'b0;
      ld_valid_q  <= 1'b0;
      if (abort_acc) begin
        state_q   <= ST_IDLE;
        ld_rstn_q <= 1'b1;
        ld_mode_q <= 1'b1;
        busy_q    <= 1'b0;
        para_ok_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE, ST_READY: begin
            if (start_acc) begin
              state_q   <= ST_CLR;
              clr_cnt_q <= '0;
              ld_rstn_q <= 1'b0;
              ld_mode_q <= 1'b0;
              busy_q    <= 1'b1;
              para_ok_q <= 1'b0;
            end
          end
          ST_CLR: begin
            if (clr_cnt_q == CLR_LAST) begin
              state_q   <= ST_LOAD;
              ld_rstn_q <= 1'b1;
            end else begin
              clr_cnt_q <= clr_cnt_q + CLRW'(1);
            end
          end
          ST_LOAD: begin
            if (hs) begin
              ld_valid_q <= 1'b1;
              ld_para_q  <= bus.src_data;
              if (last_word) state_q <= ST_DRAIN;
            end
          end
          ST_DRAIN: begin
            state_q     <= ST_READY;
            ld_mode_q   <= 1'b1;
            para_ok_q   <= 1'b1;
            load_done_q <= 1'b1;
            busy_q      <= 1'b0;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.ld_rstn  = ld_rstn_q;
  assign bus.ld_valid = ld_valid_q;
  assign bus.ld_mode  = ld_mode_q;
  assign bus.ld_para  = ld_para_q;
  assign busy         = busy_q;
  assign para_ok      = para_ok_q;
  assign load_done    = load_done_q;

endmodule

// File: tb/tb_para_load_ctrl.sv
// Scoreboard bench for para_load_ctrl with a behavioural loader model.
module tb_para_load_ctrl;
  import para_pkg::*;

  localparam int TOTAL = TOTAL_DEF;
  localparam int FM    = FM_DEPTH_DEF;
  localparam int CH    = CHANNEL_NUM_DEF;
  localparam int PN    = PARA_NUM_DEF;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          busy, para_ok, load_done;
  logic [2:0]    seg_idx;
  logic [CW-1:0] word_cnt;

  para_load_ctrl_if #(.PARA_WIDTH(16)) bus ();

  para_load_ctrl dut (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start),
    .abort    (abort),
    .bus      (bus),
    .busy     (busy),
    .para_ok  (para_ok),
    .load_done(load_done),
    .seg_idx  (seg_idx),
    .word_cnt (word_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic signed [15:0] exp_q[$];
  logic signed [15:0] mem [TOTAL];
  int lcnt = 0, clr_low = 0, vpulses = 0, done_cnt = 0, prev_wc = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Segment a word count belongs to, straight from the image layout.
  function automatic int seg_of(input int w);
    int s;
    if (w < FM) return 0;
    s = 1 + (w - FM) / CH;
    return (s > PN - 1) ? PN - 1 : s;
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_ld_rstn"},   bus.ld_rstn,   1);
    chk({tag, "_ld_mode"},   bus.ld_mode,   1);
    chk({tag, "_ld_valid"},  bus.ld_valid,  0);
    chk({tag, "_ld_para"},   bus.ld_para,   0);
    chk({tag, "_busy"},      busy,          0);
    chk({tag, "_para_ok"},   para_ok,       0);
    chk({tag, "_load_done"}, load_done,     0);
    chk({tag, "_seg_idx"},   seg_idx,       0);
    chk({tag, "_word_cnt"},  word_cnt,      0);
    chk({tag, "_src_ready"}, bus.src_ready, 0);
  endtask

  // Monitor: loader model + scoreboard pop on every ld_valid.
  always @(negedge clk) begin
    logic signed [15:0] e;
    if (!rstn) begin
      exp_q.delete();
      lcnt = 0;
    end else begin
      if (!bus.ld_rstn) begin
        lcnt = 0;
        clr_low++;
      end
      if (bus.ld_valid) begin
        vpulses++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL ld_valid_unexpected: got ld_para %0d with no word outstanding", bus.ld_para);
        end else begin
          e = exp_q.pop_front();
          chk("ld_para", bus.ld_para, e);
        end
        chk("ld_mode_during_valid", bus.ld_mode, 0);
        if (lcnt < TOTAL) mem[lcnt] = bus.ld_para;
        lcnt++;
        chk("loader_pulses_le_total", lcnt <= TOTAL, 1);
      end
      if (load_done) done_cnt++;
      if (int'(word_cnt) != prev_wc) begin
        chk("seg_idx_vs_word_cnt", seg_idx, seg_of(int'(word_cnt)));
        prev_wc = int'(word_cnt);
      end
    end
  end

  // One load: start pulse, random-valid stream of base+index, optional ignored
  // start at start_at, optional abort / async reset when word_cnt reaches kill_at.
  task automatic load_img(input int base, input int pct, input int start_at,
                          input int kill_at, input bit use_rst);
    int idx = 0;
    int n = 0;
    bit st_done = 0;
    bit killed = 0;
    clr_low = 0; vpulses = 0; done_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_busy",     busy,        1);
    chk("start_para_ok",  para_ok,     0);
    chk("start_ld_rstn",  bus.ld_rstn, 0);
    chk("start_ld_mode",  bus.ld_mode, 0);
    chk("start_word_cnt", word_cnt,    0);
    while (n < 5000 && !killed && done_cnt == 0) begin
      bus.src_valid = ($urandom_range(99) < pct);
      bus.src_data  = 16'(base + idx);
      start = 1'b0;
      abort = 1'b0;
      if (bus.src_ready && idx == start_at && !st_done) begin
        start = 1'b1;
        st_done = 1;
      end
      if (bus.src_ready && idx == kill_at) begin
        killed = 1;
        bus.src_valid = 1'b0;
        chk("kill_word_cnt", word_cnt, idx);
        if (use_rst) begin
          #1 rstn = 1'b0;
          #1 chk_reset("async_rst");
          @(posedge clk); #3;
          rstn = 1'b1;
          @(negedge clk);
          chk_reset("after_rst");
        end else begin
          abort = 1'b1;
          @(posedge clk); #1;
          abort = 1'b0;
          chk("abort_src_ready", bus.src_ready, 0);
          chk("abort_busy",      busy,          0);
          chk("abort_ld_mode",   bus.ld_mode,   1);
          chk("abort_ld_rstn",   bus.ld_rstn,   1);
          chk("abort_ld_valid",  bus.ld_valid,  0);
          chk("abort_para_ok",   para_ok,       0);
          chk("abort_word_cnt",  word_cnt,      kill_at);
          @(negedge clk);
          chk("abort_queue_empty", exp_q.size(), 0);
        end
      end else begin
        @(negedge clk);
        if (bus.src_valid && bus.src_ready) begin
          exp_q.push_back(16'(base + idx));
          idx++;
        end
        @(posedge clk); #1;
        n++;
      end
    end
    bus.src_valid = 1'b0;
    start = 1'b0;
    if (!killed) begin
      chk("load_within_budget", n < 5000, 1);
      chk("clear_cycles",   clr_low,       CLR_CYCLES_DEF);
      chk("valid_pulses",   vpulses,       TOTAL);
      chk("load_done_once", done_cnt,      1);
      chk("load_done_low",  load_done,     0);
      chk("para_ok",        para_ok,       1);
      chk("ready_ld_mode",  bus.ld_mode,   1);
      chk("ready_busy",     busy,          0);
      chk("ready_src_rdy",  bus.src_ready, 0);
      chk("final_word_cnt", word_cnt,      TOTAL);
      chk("final_seg_idx",  seg_idx,       PN - 1);
      chk("queue_empty",    exp_q.size(),  0);
      chk("rsign_63",       mem[FM - 1],    base + FM - 1);
      chk("bn_a_0",         mem[FM],        base + FM);
      chk("zeta_127",       mem[TOTAL - 1], base + TOTAL - 1);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.src_valid = 1'b0;
    bus.src_data  = '0;
    #12;
    chk_reset("reset");
    @(posedge clk); #3;
    rstn = 1'b1;

    load_img(0,    100, -1, -1,  0);  // full-rate load from IDLE
    load_img(0,     50, 10, -1,  0);  // gappy reload from READY, stray start at word 10
    load_img(1000,  70, -1, -1,  0);  // reload with shifted data
    load_img(0,     80, -1, 300, 0);  // abort mid-image

    // start and abort together in IDLE: stays idle
    clr_low = 0;
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk("sa_busy",      busy,          0);
    chk("sa_ld_rstn",   bus.ld_rstn,   1);
    chk("sa_src_ready", bus.src_ready, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("sa_no_clear",  clr_low,       0);
    chk("sa_still_idle", busy,         0);

    load_img(0,    100, -1, -1,  0);  // reload after abort
    load_img(0,     60, -1, 500, 1);  // async reset mid-image
    load_img(0,    100, -1, -1,  0);  // recovery after reset

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
